// File: rtl/ifetch_unit.sv
// ifetch_unit: instruction-fetch control between the PC register and decode.
// Issues word requests, holds the returned instruction, gates PC advance, flags faults.
`default_nettype none

module ifetch_unit #(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [31:0]      pc_q,
    output logic             pc_ce,
    input  logic             flush,
    output logic             imem_req,
    output logic [31:0]      imem_addr,
    input  logic             imem_ack,
    input  logic [31:0]      imem_rdata,
    output logic [31:0]      inst,
    output logic             inst_valid,
    input  logic             inst_ready,
    output logic             fetch_fault,
    output logic [1:0]       fault_code,
    output logic [CNT_W-1:0] fetch_count
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_REQ   = 3'd1;
    localparam logic [2:0] S_HOLD  = 3'd2;
    localparam logic [2:0] S_DROP  = 3'd3;
    localparam logic [2:0] S_FAULT = 3'd4;

    logic [2:0] state;
    logic [7:0] wait_cnt;
    logic       aligned;
    logic       timeout_hit;

    assign aligned     = (pc_q[1:0] == 2'b00);
    // Fires on the TIMEOUT-th consecutive cycle without an ack.
    assign timeout_hit = (wait_cnt == 8'(TIMEOUT - 1));

    assign imem_req  = (state == S_REQ) && aligned;
    assign imem_addr = pc_q;
    assign pc_ce     = ((state == S_HOLD) && inst_ready) || flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= S_IDLE;
            wait_cnt    <= 8'd0;
            inst        <= 32'd0;
            inst_valid  <= 1'b0;
            fetch_fault <= 1'b0;
            fault_code  <= 2'b00;
            fetch_count <= '0;
        end else if (flush) begin
            // An outstanding request with no ack yet must have its late ack absorbed.
            inst_valid  <= 1'b0;
            wait_cnt    <= 8'd0;
            fetch_fault <= 1'b0;
            fault_code  <= 2'b00;
            state       <= ((state == S_REQ) && !imem_ack) ? S_DROP : S_REQ;
        end else begin
            case (state)
                S_IDLE: begin
                    wait_cnt <= 8'd0;
                    state    <= S_REQ;
                end
                S_REQ: begin
                    if (!aligned) begin
                        fetch_fault <= 1'b1;
                        fault_code  <= 2'b01;
                        wait_cnt    <= 8'd0;
                        state       <= S_FAULT;
                    end else if (imem_ack) begin
                        inst       <= imem_rdata;
                        inst_valid <= 1'b1;
                        wait_cnt   <= 8'd0;
                        state      <= S_HOLD;
                    end else if (timeout_hit) begin
                        fetch_fault <= 1'b1;
                        fault_code  <= 2'b10;
                        wait_cnt    <= 8'd0;
                        state       <= S_FAULT;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_HOLD: begin
                    if (inst_ready) begin
                        fetch_count <= fetch_count + CNT_W'(1);
                        inst_valid  <= 1'b0;
                        state       <= S_REQ;
                    end
                end
                S_DROP: begin
                    if (imem_ack || timeout_hit) begin
                        wait_cnt <= 8'd0;
                        state    <= S_REQ;
                    end else begin
                        wait_cnt <= wait_cnt + 8'd1;
                    end
                end
                S_FAULT: begin
                    inst_valid <= 1'b0;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_ifetch_unit.sv
// Directed testbench for ifetch_unit with immediate-assertion checks.
`default_nettype none

module tb_ifetch_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] pc_q;
    logic        pc_ce;
    logic        flush;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] inst;
    logic        inst_valid;
    logic        inst_ready;
    logic        fetch_fault;
    logic [1:0]  fault_code;
    logic [3:0]  fetch_count;

    int checks = 0;
    int errors = 0;

    ifetch_unit #(.TIMEOUT(16), .CNT_W(4)) dut (
        .clk(clk), .rst(rst), .pc_q(pc_q), .pc_ce(pc_ce), .flush(flush),
        .imem_req(imem_req), .imem_addr(imem_addr), .imem_ack(imem_ack),
        .imem_rdata(imem_rdata), .inst(inst), .inst_valid(inst_valid),
        .inst_ready(inst_ready), .fetch_fault(fetch_fault),
        .fault_code(fault_code), .fetch_count(fetch_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; pc_q = 32'h0; imem_ack = 1'b0;
        imem_rdata = 32'h0; inst_ready = 1'b0;
        #2;
        chk("rst_req",   32'(imem_req), 32'd0);
        chk("rst_inst",  inst, 32'd0);
        chk("rst_valid", 32'(inst_valid), 32'd0);
        chk("rst_fault", 32'(fetch_fault), 32'd0);
        chk("rst_code",  32'(fault_code), 32'd0);
        chk("rst_count", 32'(fetch_count), 32'd0);
        chk("rst_pcce",  32'(pc_ce), 32'd0);
        flush = 1'b1; #1;
        chk("rst_pcce_flush", 32'(pc_ce), 32'd1);
        flush = 1'b0;

        // Basic fetch: ack one cycle after request
        step(); rst = 1'b0;
        step();                               // now S_REQ
        #1;
        chk("t1_req",  32'(imem_req), 32'd1);
        chk("t1_addr", imem_addr, 32'h0);
        step();
        imem_ack = 1'b1; imem_rdata = 32'h20080005; inst_ready = 1'b1; #1;
        chk("t1_no_comb_valid", 32'(inst_valid), 32'd0);
        chk("t1_pcce_req", 32'(pc_ce), 32'd0);
        step(); imem_ack = 1'b0; #1;
        chk("t1_inst",  inst, 32'h20080005);
        chk("t1_valid", 32'(inst_valid), 32'd1);
        chk("t1_pcce",  32'(pc_ce), 32'd1);
        chk("t1_hold_req", 32'(imem_req), 32'd0);
        step(); inst_ready = 1'b0; pc_q = 32'h4; #1;
        chk("t1_count", 32'(fetch_count), 32'd1);
        chk("t1_valid_clr", 32'(inst_valid), 32'd0);
        chk("t1_pcce_off", 32'(pc_ce), 32'd0);
        chk("t1_next_addr", imem_addr, 32'h4);
        chk("t1_next_req", 32'(imem_req), 32'd1);

        // Decode stall for 5 cycles
        imem_ack = 1'b1; imem_rdata = 32'hAABBCCDD;
        step(); imem_ack = 1'b0;
        for (int i = 0; i < 5; i++) begin
            #1;
            chk("t2_inst",  inst, 32'hAABBCCDD);
            chk("t2_valid", 32'(inst_valid), 32'd1);
            chk("t2_pcce",  32'(pc_ce), 32'd0);
            chk("t2_req",   32'(imem_req), 32'd0);
            step();
        end
        inst_ready = 1'b1; #1;
        chk("t2_pcce_on", 32'(pc_ce), 32'd1);
        step(); inst_ready = 1'b0; #1;
        chk("t2_count", 32'(fetch_count), 32'd2);
        chk("t2_pcce_single", 32'(pc_ce), 32'd0);

        // Misaligned PC
        pc_q = 32'h6; #1;
        chk("t3_no_req", 32'(imem_req), 32'd0);
        step();
        chk("t3_fault", 32'(fetch_fault), 32'd1);
        chk("t3_code",  32'(fault_code), 32'd1);
        step();
        chk("t3_sticky", 32'(fetch_fault), 32'd1);
        chk("t3_req_off", 32'(imem_req), 32'd0);
        flush = 1'b1; pc_q = 32'h8; #1;
        chk("t3_flush_pcce", 32'(pc_ce), 32'd1);
        step(); flush = 1'b0; #1;
        chk("t3_fault_clr", 32'(fetch_fault), 32'd0);
        chk("t3_code_clr", 32'(fault_code), 32'd0);
        chk("t3_resume_req", 32'(imem_req), 32'd1);
        chk("t3_resume_addr", imem_addr, 32'h8);

        // Time-out after exactly 16 request cycles
        for (int i = 0; i < 16; i++) begin
            chk("t4_req_hold", 32'(imem_req), 32'd1);
            chk("t4_no_fault", 32'(fetch_fault), 32'd0);
            step();
        end
        chk("t4_fault", 32'(fetch_fault), 32'd1);
        chk("t4_code",  32'(fault_code), 32'd2);
        chk("t4_req_off", 32'(imem_req), 32'd0);
        flush = 1'b1; pc_q = 32'h10;
        step(); flush = 1'b0; #1;
        chk("t4_resume_req", 32'(imem_req), 32'd1);

        // Flush during request; late ack discarded
        flush = 1'b1; pc_q = 32'h20;
        step(); flush = 1'b0; #1;
        chk("t5_drop_req", 32'(imem_req), 32'd0);
        chk("t5_drop_valid", 32'(inst_valid), 32'd0);
        step();
        step();
        imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
        step(); imem_ack = 1'b0; #1;
        chk("t5_valid", 32'(inst_valid), 32'd0);
        chk("t5_inst_kept", inst, 32'hAABBCCDD);
        chk("t5_req", 32'(imem_req), 32'd1);
        chk("t5_addr", imem_addr, 32'h20);

        // Asynchronous reset in the middle of a request
        rst = 1'b1; #1;
        chk("t6_rst_req",   32'(imem_req), 32'd0);
        chk("t6_rst_inst",  inst, 32'd0);
        chk("t6_rst_count", 32'(fetch_count), 32'd0);
        chk("t6_rst_valid", 32'(inst_valid), 32'd0);
        step(); rst = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h12345678; pc_q = 32'h0;
        step(); #1;
        chk("t6_idle_no_capture", inst, 32'd0);
        chk("t6_idle_valid", 32'(inst_valid), 32'd0);

        // 17 zero-wait fetches: 4-bit counter wraps to 1
        for (int i = 0; i < 17; i++) begin
            imem_ack = 1'b1;
            step(); imem_ack = 1'b0; inst_ready = 1'b1; #1;
            chk("t7_valid", 32'(inst_valid), 32'd1);
            chk("t7_pcce",  32'(pc_ce), 32'd1);
            step(); inst_ready = 1'b0; #1;
            chk("t7_count", 32'(fetch_count), 32'((i + 1) % 16));
        end
        chk("t7_wrap", 32'(fetch_count), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

`default_nettype wire
